// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Counts BUSY cycles without a memory ack; flags expiry on the cycle that reaches the limit.
// Combinational expiry so the FSM can leave BUSY on the same edge the limit is hit.
module mem_arb_watchdog #(
    parameter int unsigned LIMIT = 255
)(
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] count;

    // Held at zero outside BUSY, so every BUSY entry starts from a clean count.
    always_ff @(posedge clk) begin
        if (!rst_n || !busy) begin
            count <= '0;
        end else if (!ack) begin
            count <= count + 1'b1;
        end
    end

    assign expired = busy && !ack && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and load/store with alternating-priority grants.
// Optional watchdog under MEM_ARB_TIMEOUT_EN; without it BUSY waits indefinitely and err_o is 0.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 30,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    arb_state_t        state;
    gnt_t              last_grant;
    logic              expired;
    logic              busy;
    logic              done;
    logic              d_wins;
    logic [DATA_W-1:0] resp_data;

    assign busy      = (state == ST_BUSY_IF) || (state == ST_BUSY_D);
    assign done      = busy && (mem_ack_i || expired);
    assign d_wins    = d_req_i && (!if_req_i || (last_grant == GNT_IF));
    assign resp_data = mem_ack_i ? mem_rdata_i : DATA_W'(ERR_DATA);
    assign stall_o   = d_req_i & ~d_ack_o;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .busy    (busy),
        .ack     (mem_ack_i),
        .expired (expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_o <= 1'b0;
        end else if (expired) begin
            err_o <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            last_grant  <= GNT_IF;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            if_data_o   <= '0;
            d_rdata_o   <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_wins) begin
                        state       <= ST_BUSY_D;
                        last_grant  <= GNT_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                    end else if (if_req_i) begin
                        state       <= ST_BUSY_IF;
                        last_grant  <= GNT_IF;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (done) begin
                        state     <= ST_RESP;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (state == ST_BUSY_D) begin
                            d_ack_o   <= 1'b1;
                            // Stores carry no read data back to stage4.
                            d_rdata_o <= (mem_we_o && mem_ack_i) ? '0 : resp_data;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= resp_data;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
